// File: rtl/mux_dft_pkg.sv
// Shared DFT definitions for the mux BIST controller: FSM encoding, register widths,
// MISR polynomial and the pattern-generator step function.
package mux_dft_pkg;

  localparam int unsigned LFSR_W = 6;
  localparam int unsigned MISR_W = 8;
  localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } bist_state_t;

  // Fibonacci x^6+x^5+1: shift left, feed back the xor of the top two taps
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[LFSR_W-2]};
  endfunction

endpackage

// File: rtl/dft_misr.sv
// Multiple-input signature register: shift-left Galois compactor with a synchronous
// clear and a capture enable, reusable for any DFT response width.
module dft_misr #(
  parameter int unsigned     MISR_W = 8,
  parameter logic [MISR_W-1:0] POLY = 8'h1D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [MISR_W-1:0] din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] feedback;

  always_comb begin
    feedback = sig[MISR_W-1] ? POLY : {MISR_W{1'b0}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= {MISR_W{1'b0}};
    end else if (clear) begin
      sig <= {MISR_W{1'b0}};
    end else if (enable) begin
      sig <= {sig[MISR_W-2:0], 1'b0} ^ feedback ^ din;
    end
  end

endmodule

// File: rtl/mux_bist_ctrl.sv
// Logic-BIST controller around a 4:1 mux: LFSR patterns drive the mux inputs, a MISR
// compacts the mux output, and the final signature is compared against a golden value.
module mux_bist_ctrl
  import mux_dft_pkg::*;
#(
  parameter int unsigned       PATTERN_COUNT = 63,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 6'h01,
  parameter logic [MISR_W-1:0] GOLDEN_SIG    = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mux_out,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic [1:0]        selc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fault_indicator,
  output logic [MISR_W-1:0] signature
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERN_COUNT - 1);

  bist_state_t       state, state_next;
  logic [LFSR_W-1:0] lfsr, lfsr_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              pass_q, pass_next;
  logic              busy_q, done_q, fault_q;
  logic              misr_clear, misr_en;

  // State and datapath registers; status flags are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= LFSR_SEED;
      cnt     <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_next;
      lfsr    <= lfsr_next;
      cnt     <= cnt_next;
      pass_q  <= pass_next;
      busy_q  <= (state_next == RUN) || (state_next == CMP);
      done_q  <= (state_next == DONE);
      fault_q <= (state_next == DONE) && !pass_next;
    end
  end

  // Next-state and control; abort wins over everything including start
  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    cnt_next   = cnt;
    pass_next  = pass_q;
    misr_clear = 1'b0;
    misr_en    = 1'b0;
    if (abort) begin
      state_next = IDLE;
      pass_next  = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state_next = RUN;
            lfsr_next  = LFSR_SEED;
            cnt_next   = '0;
            pass_next  = 1'b0;
            misr_clear = 1'b1;
          end
        end
        RUN: begin
          misr_en   = 1'b1;
          lfsr_next = lfsr_step(lfsr);
          cnt_next  = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_next = CMP;
          end
        end
        CMP: begin
          pass_next  = (signature == GOLDEN_SIG);
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  dft_misr #(
    .MISR_W (MISR_W),
    .POLY   (MISR_POLY)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .clear  (misr_clear),
    .enable (misr_en),
    .din    (MISR_W'(mux_out)),
    .sig    (signature)
  );

  // Pattern outputs are the LFSR register bits themselves
  assign {a, b, c, d, selc} = lfsr;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign fault_indicator    = fault_q;

endmodule

// File: tb/tb_mux_bist_ctrl.sv
// Scoreboard bench for mux_bist_ctrl: a behavioural 4:1 mux (optionally stuck-at) closes
// the loop; completed runs are checked against queued expectations by a done monitor.
module tb_mux_bist_ctrl;

  function automatic logic [7:0] model_sig(input int mode);
    logic [5:0] l;
    logic [7:0] m;
    logic       o;
    l = 6'h01;
    m = 8'h00;
    for (int i = 0; i < 63; i++) begin
      case (l[1:0])
        2'd0:    o = l[5];
        2'd1:    o = l[4];
        2'd2:    o = l[3];
        default: o = l[2];
      endcase
      if (mode == 1) o = 1'b0;
      else if (mode == 2) o = 1'b1;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {7'b0, o};
      l = {l[4:0], l[5] ^ l[4]};
    end
    return m;
  endfunction

  localparam logic [7:0] GOLDEN = model_sig(0);
  localparam logic [7:0] SA1_SIG = model_sig(2);

  logic       clk = 1'b0;
  logic       rst, start, abort, mux_out;
  logic       a, b, c, d, busy, done, pass, fault_indicator;
  logic [1:0] selc;
  logic [7:0] signature;
  int         fault_mode;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    string      name;
    logic [7:0] sig;
    logic       pass;
    logic       fault;
    int         done_cyc;
  } exp_t;
  exp_t q[$];

  mux_bist_ctrl #(
    .PATTERN_COUNT (63),
    .LFSR_SEED     (6'h01),
    .GOLDEN_SIG    (GOLDEN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .mux_out         (mux_out),
    .a               (a),
    .b               (b),
    .c               (c),
    .d               (d),
    .selc            (selc),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fault_indicator (fault_indicator),
    .signature       (signature)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (selc)
      2'd0:    mux_out = a;
      2'd1:    mux_out = b;
      2'd2:    mux_out = c;
      default: mux_out = d;
    endcase
    if (fault_mode == 1) mux_out = 1'b0;
    else if (fault_mode == 2) mux_out = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising done retires one queued expectation
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
      end else begin
        e = q.pop_front();
        check({e.name, "_sig"},   32'(signature),       32'(e.sig));
        check({e.name, "_pass"},  32'(pass),            32'(e.pass));
        check({e.name, "_fault"}, 32'(fault_indicator), 32'(e.fault));
        check({e.name, "_cycle"}, 32'(cyc),             32'(e.done_cyc));
      end
    end
    done_prev <= done;
  end

  task automatic start_run(input string name, input bit expect_done,
                           input logic [7:0] sig, input logic p);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    if (expect_done) begin
      e.name     = name;
      e.sig      = sig;
      e.pass     = p;
      e.fault    = ~p;
      e.done_cyc = cyc + 1 + 64;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got done=0 expected done within 200 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},  32'(busy), 32'(0));
    check({name, "_done"},  32'(done), 32'(0));
    check({name, "_pass"},  32'(pass), 32'(0));
    check({name, "_fault"}, 32'(fault_indicator), 32'(0));
    check({name, "_sig"},   32'(signature), 32'(0));
    check({name, "_pat"},   32'({a, b, c, d, selc}), 32'(6'b000001));
  endtask

  initial begin
    logic [5:0] pat_hold;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fault_mode = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Good run: first patterns, completion, then hold in DONE
    start_run("good", 1'b1, GOLDEN, 1'b1);
    check("first_pat", 32'({a, b, c, d, selc}), 32'(6'b000001));
    check("first_mux", 32'(mux_out), 32'(0));
    check("busy_run",  32'(busy), 32'(1));
    @(negedge clk);
    check("second_pat", 32'({a, b, c, d, selc}), 32'(6'b000010));
    wait_done("good");
    pat_hold = {a, b, c, d, selc};
    repeat (3) @(negedge clk);
    check("hold_pat",  32'({a, b, c, d, selc}), 32'(pat_hold));
    check("hold_sig",  32'(signature), 32'(GOLDEN));
    check("hold_done", 32'(done), 32'(1));
    check("hold_busy", 32'(busy), 32'(0));

    // Stuck-at faults, started directly from DONE
    fault_mode = 1;
    start_run("sa0", 1'b1, 8'h00, 1'b0);
    wait_done("sa0");
    check("sa0_differs", 32'(signature != GOLDEN), 32'(1));
    fault_mode = 2;
    start_run("sa1", 1'b1, SA1_SIG, 1'b0);
    wait_done("sa1");
    check("sa1_differs", 32'(signature != GOLDEN), 32'(1));
    fault_mode = 0;

    // Start pulsed mid-run is ignored
    start_run("restart_ignored", 1'b1, GOLDEN, 1'b1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart_ignored");

    // Abort mid-run, then a clean rerun
    start_run("aborted", 1'b0, 8'h00, 1'b0);
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_pass", 32'(pass), 32'(0));
    repeat (3) @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'(0));
    start_run("after_abort", 1'b1, GOLDEN, 1'b1);
    wait_done("after_abort");

    // Asynchronous reset mid-run, checked between clock edges
    start_run("reset_mid", 1'b0, 8'h00, 1'b0);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    start_run("after_rst", 1'b1, GOLDEN, 1'b1);
    wait_done("after_rst");

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
